conv_enc_tx: RTL and testbench
==============================

Name: conv_enc_tx

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder chain (branch-metric, add-compare-select and traceback stages). The block accepts a frame of data bytes over a valid/ready handshake and serialises each byte MSB first. It emits one 2-bit code symbol per data bit, then appends K-1 = 2 zero tail bits so the trellis terminates in state 00.

Parameters:
FRAME_BITS, 8, data bits per frame; must be a non-zero multiple of 8.
G0, 3'b111, generator polynomial for symbol bit 1 (octal 7); bit 2 taps u, bit 1 taps s1, bit 0 taps s0.
G1, 3'b101, generator polynomial for symbol bit 0 (octal 5); same bit mapping as G0.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  single-cycle pulse; begins a frame. Ignored unless in IDLE.
din_valid  input  1  input byte valid.
din  input  8  input byte, MSB transmitted first.
din_ready  output  1  block accepts a byte this cycle.
sym_valid  output  1  sym holds a valid code symbol.
sym  output  2  code symbol {c0, c1}.
sym_ready  input  1  downstream accepts sym this cycle.
sym_last  output  1  high together with the final tail symbol of the frame.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last symbol is accepted.

Behaviour:
- Encoder state st[1:0] = {s1, s0} = {u(n-1), u(n-2)}. This naming matches the decoder's state labels 00/01/10/11.
- For input bit u:
  - c0 = ^({u,st} & G0)
  - c1 = ^({u,st} & G1)
  - next st = {u, s1}
- Resulting transitions: 00 -> 00 or 10; 01 -> 00 or 10; 10 -> 01 or 11; 11 -> 01 or 11.
- FSM states:
  - IDLE -> LOAD on start.
  - LOAD: din_ready = 1. On din_valid & din_ready, latch din into an 8-bit shift register and go to ENC.
  - ENC: present the symbol for the current MSB. On sym_valid & sym_ready, shift the byte left, increment bit_cnt and update st. The next symbol is presented in the same cycle, giving full throughput within a byte. After the 8th bit of a byte: go to LOAD if bit_cnt < FRAME_BITS, otherwise go to TAIL.
  - TAIL: emit two symbols with u = 0. sym_last = 1 on the second. Once that symbol is accepted, go to DONE.
  - DONE: done = 1 for exactly one cycle, st forced to 00, then IDLE.
- Output registers: sym, sym_valid and sym_last are registered. They hold stable while sym_valid & !sym_ready, with no limit on stall length.
- Latency:
  - start to din_ready: 1 cycle.
  - Byte accepted to first sym_valid: 1 cycle.
  - One bubble cycle (sym_valid = 0) between bytes while in LOAD.
- Frame length: FRAME_BITS + 2 symbols. bit_cnt width is $clog2(FRAME_BITS+1) and it clears on start.
- din_ready is 0 outside LOAD. din_valid outside LOAD is ignored.
- start while busy is ignored, including start in the same cycle as done.
- Reset values, also applied on reset mid-frame:
  - All outputs = 0; st = 00; bit_cnt = 0; FSM = IDLE.
  - A partially sent frame is abandoned with no sym_last and no done.

Decomposition:
- Shared package viterbi_pkg holds:
  - K = 3, TAIL_BITS = 2.
  - G0/G1 defaults.
  - Encoder state encoding constants ST_00/ST_01/ST_10/ST_11, shared with the decoder.
  - FSM state enum enc_state_t.
- One natural sub-module: conv_enc_core. It is combinational: (u, st) -> (sym, st_next). The decoder's branch-metric unit reuses it to compute expected symbols.

Test Plan:
- FRAME_BITS = 8, start, byte 0xB0, sym_ready tied high -> sym sequence 11,10,00,01,01,11,00,00,00,00. sym_last on the 10th symbol. done one cycle later. Final st = 00.
- Byte 0xFF -> 11,01,10,10,10,10,10,10 then tail 01,11.
- Byte 0xB0 with sym_ready toggled 1,0,0,1,... pseudo-randomly -> same 10-symbol sequence. sym is stable during every stall cycle and no symbol is duplicated or dropped.
- FRAME_BITS = 16, bytes 0xFF then 0x00 -> 16 data symbols. Exactly one sym_valid = 0 bubble between byte 1 and byte 2. din_ready is high only in LOAD. Tail 00,00 because st returns to 00 after two zero bits.
- start pulsed mid-frame, and din_valid held high in ENC -> no effect on the symbol stream; exactly one byte accepted per LOAD visit.
- rst asserted after 3 symbols of a frame -> all outputs 0 asynchronously. A new start with 0xB0 produces the full reference sequence from symbol 11, proving st restarted at 00.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder and the Viterbi decoder chain.
// Holds the code constants (K, tail length, default generators), the trellis
// state labels and the encoder FSM state type.
package viterbi_pkg;

  localparam int K         = 3;
  localparam int TAIL_BITS = K - 1;

  // Generator taps: bit 2 = u, bit 1 = s1, bit 0 = s0
  localparam logic [2:0] G0_DEF = 3'b111;  // octal 7
  localparam logic [2:0] G1_DEF = 3'b101;  // octal 5

  // Trellis state labels {s1, s0} = {u(n-1), u(n-2)}
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ENC  = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } enc_state_t;

endpackage

// File: rtl/conv_enc_core.sv
// One trellis step of the rate-1/2, K=3 convolutional code. Purely combinational.
// Also used by the decoder's branch-metric unit to form expected symbols.
// Ports:
//   u       input bit
//   st      current encoder state {s1, s0}
//   sym     code symbol {c0, c1}
//   st_next state after consuming u
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input  logic       u,
  input  logic [1:0] st,
  output logic [1:0] sym,
  output logic [1:0] st_next
);

  logic [2:0] taps;

  assign taps    = {u, st};
  assign sym     = {^(taps & G0), ^(taps & G1)};
  assign st_next = {u, st[1]};

endmodule

// File: rtl/conv_enc_tx.sv
// Transmit-side convolutional encoder. Accepts FRAME_BITS/8 bytes over a
// valid/ready handshake, sends them MSB first as 2-bit code symbols, then adds
// two zero tail bits so the trellis ends in state 00.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    begins a frame (IDLE only)
//   din_valid, din, din_ready  byte input handshake
//   sym_valid, sym, sym_ready  symbol output handshake (registered outputs)
//   sym_last                 marks the final tail symbol
//   busy                     high outside IDLE
//   done                     one-cycle pulse after the last symbol is taken
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | din_ready high, waiting for the next byte (symbol bubble)
// ENC   | sending the data symbols of the current byte
// TAIL  | sending the two zero-input termination symbols
// DONE  | one-cycle done pulse, trellis state forced to 00
module conv_enc_tx
  import viterbi_pkg::*;
#(
  parameter int         FRAME_BITS = 8,
  parameter logic [2:0] G0         = G0_DEF,
  parameter logic [2:0] G1         = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din_valid,
  input  logic [7:0] din,
  output logic       din_ready,
  output logic       sym_valid,
  output logic [1:0] sym,
  input  logic       sym_ready,
  output logic       sym_last,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  enc_state_t state, state_next;

  // The byte MSB is already in flight once loaded, so only the 7 remaining
  // bits need to be held.
  logic [6:0]    shreg;
  logic [1:0]    st;       // trellis state, advances on symbol acceptance
  logic [1:0]    st_look;  // trellis state after the symbol currently presented
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_inc;
  logic          tail_cnt;

  logic          din_hs;
  logic          sym_hs;
  logic          byte_end;
  logic          frame_end;

  logic          core_u;
  logic [1:0]    core_st;
  logic [1:0]    core_sym;
  logic [1:0]    core_st_next;

  assign din_hs      = din_valid & din_ready;
  assign sym_hs      = sym_valid & sym_ready;
  assign bit_cnt_inc = bit_cnt + CW'(1);
  assign byte_end    = (bit_cnt[2:0] == 3'd7);
  assign frame_end   = (bit_cnt_inc == CW'(FRAME_BITS));

  // The core always computes the symbol to be presented next: in LOAD that is
  // the incoming MSB from the settled state, otherwise the following bit from
  // the state after the symbol now on the output.
  always_comb begin
    core_u  = 1'b0;
    core_st = st_look;
    if (state == LOAD) begin
      core_u  = din[7];
      core_st = st;
    end else if (state == ENC && !byte_end) begin
      core_u  = shreg[6];
    end
  end

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .u       (core_u),
    .st      (core_st),
    .sym     (core_sym),
    .st_next (core_st_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)  state_next = LOAD;
      LOAD: if (din_hs) state_next = ENC;
      ENC:  if (sym_hs && byte_end) state_next = frame_end ? TAIL : LOAD;
      TAIL: if (sym_hs && tail_cnt) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state == LOAD);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      st        <= ST_00;
      st_look   <= ST_00;
      bit_cnt   <= '0;
      tail_cnt  <= 1'b0;
      sym       <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt  <= '0;
            tail_cnt <= 1'b0;
          end
        end
        LOAD: begin
          if (din_hs) begin
            shreg     <= din[6:0];
            sym       <= core_sym;
            st_look   <= core_st_next;
            sym_valid <= 1'b1;
            sym_last  <= 1'b0;
          end
        end
        ENC: begin
          if (sym_hs) begin
            shreg   <= {shreg[5:0], 1'b0};
            bit_cnt <= bit_cnt_inc;
            st      <= st_look;
            if (byte_end && !frame_end) begin
              sym_valid <= 1'b0;
            end else begin
              sym     <= core_sym;
              st_look <= core_st_next;
            end
          end
        end
        TAIL: begin
          if (sym_hs) begin
            st <= st_look;
            if (!tail_cnt) begin
              tail_cnt <= 1'b1;
              sym      <= core_sym;
              st_look  <= core_st_next;
              sym_last <= 1'b1;
            end else begin
              sym_valid <= 1'b0;
              sym_last  <= 1'b0;
            end
          end
        end
        DONE: begin
          st      <= ST_00;
          st_look <= ST_00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_tx.sv
module tb_conv_enc_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       din_valid = 1'b0;
  logic       sym_ready = 1'b0;
  logic [7:0] din = 8'h00;

  logic       start8, start16;
  logic       dr8, sv8, sl8, b8, d8;
  logic       dr16, sv16, sl16, b16, d16;
  logic [1:0] s8, s16;

  logic       din_ready, sym_valid, sym_last, busy, done;
  logic [1:0] sym;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Only the selected instance ever sees start; the other stays in IDLE.
  assign start8    = start & ~sel;
  assign start16   = start & sel;
  assign din_ready = sel ? dr16 : dr8;
  assign sym_valid = sel ? sv16 : sv8;
  assign sym       = sel ? s16  : s8;
  assign sym_last  = sel ? sl16 : sl8;
  assign busy      = sel ? b16  : b8;
  assign done      = sel ? d16  : d8;

  conv_enc_tx #(.FRAME_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .din_valid(din_valid), .din(din),
    .din_ready(dr8), .sym_valid(sv8), .sym(s8), .sym_ready(sym_ready),
    .sym_last(sl8), .busy(b8), .done(d8)
  );

  conv_enc_tx #(.FRAME_BITS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .din_valid(din_valid), .din(din),
    .din_ready(dr16), .sym_valid(sv16), .sym(s16), .sym_ready(sym_ready),
    .sym_last(sl16), .busy(b16), .done(d16)
  );

  typedef struct {
    int          fb;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          rmode;
    bit          noise;
    logic [35:0] exp;
  } vec_t;

  localparam logic [35:0] EXP_B0  = {20'b11100001011100000000, 16'b0};
  localparam logic [35:0] EXP_FF  = {20'b11011010101010100111, 16'b0};
  localparam logic [35:0] EXP_16  = {16'b1101101010101010, 4'b0111, 16'b0};

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: shift-register encoder with integer state s = 2*u(n-1) + u(n-2),
  // c0 = parity of taps 7 (octal), c1 = parity of taps 5 (octal).
  function automatic void model(input int fb, input logic [7:0] b0, input logic [7:0] b1,
                                output logic [35:0] pk, output int n);
    int s, u, r, c0, c1;
    s  = 0;
    pk = '0;
    n  = fb + 2;
    for (int i = 0; i < n; i++) begin
      if (i < fb) u = (i < 8) ? int'(b0[7-i]) : int'(b1[15-i]);
      else        u = 0;
      r  = 4 * u + s;
      c0 = $countones(r & 7) % 2;
      c1 = $countones(r & 5) % 2;
      pk[35-2*i -: 2] = {c0[0], c1[0]};
      s  = 2 * u + s / 2;
    end
  endfunction

  task automatic run_frame(input string tag, input int fb, input logic [7:0] b0,
                           input logic [7:0] b1, input int rmode, input bit noise,
                           input bit use_tbl, input logic [35:0] texp);
    logic [35:0] mexp, gpk;
    int n, nbytes, bi, cyc, got, acc_cyc, first_cyc, last_cyc, done_cyc;
    int bubbles, loads, lasts, last_idx, stall_bad, dr_bad;
    bit held_v, pulsed, hs_sym, hs_din;
    logic [1:0] held_s;
    logic held_l;
    logic [1:0] fin_st;

    model(fb, b0, b1, mexp, n);
    nbytes = fb / 8;
    bi = 0; cyc = 0; got = 0;
    acc_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    bubbles = 0; loads = 0; lasts = 0; last_idx = -1; stall_bad = 0; dr_bad = 0;
    held_v = 0; pulsed = 0; held_s = 2'b00; held_l = 1'b0; gpk = '0;

    sel = (fb == 16);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " start->din_ready"}, din_ready, 1);

    while (done_cyc < 0 && cyc < 400) begin
      if (held_v && (sym !== held_s || sym_valid !== 1'b1 || sym_last !== held_l)) stall_bad++;
      if (din_ready) begin
        loads++;
        if (sym_valid || !busy) dr_bad++;
      end
      if (first_cyc >= 0 && busy && !sym_valid && !done) bubbles++;
      if (sym_valid && first_cyc < 0) first_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
      end else begin
        sym_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        din_valid = noise || (din_ready && bi < nbytes);
        din       = (bi < nbytes) ? ((bi == 0) ? b0 : b1) : 8'hA5;
        start     = noise && !pulsed && got == 3;
        if (start) pulsed = 1;
        hs_sym = sym_valid && sym_ready;
        hs_din = din_valid && din_ready;
        held_v = sym_valid && !sym_ready;
        held_s = sym;
        held_l = sym_last;
        if (hs_sym) begin
          if (got < 18) gpk[35-2*got -: 2] = sym;
          if (sym_last) begin
            lasts++;
            last_idx = got;
          end
          got++;
          last_cyc = cyc;
        end
        if (hs_din) begin
          if (bi == 0) acc_cyc = cyc;
          bi++;
        end
        @(negedge clk);
        cyc++;
      end
    end

    // start during the done cycle must be ignored
    din_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin_st = sel ? dut16.st : dut8.st;

    chk({tag, " completed in budget"}, done_cyc >= 0, 1);
    chk({tag, " sequence vs model"}, gpk, mexp);
    if (use_tbl) chk({tag, " sequence vs table"}, gpk, texp);
    chk({tag, " symbol count"}, got, n);
    chk({tag, " sym_last count"}, lasts, 1);
    chk({tag, " sym_last position"}, last_idx, n - 1);
    chk({tag, " done latency"}, done_cyc - last_cyc, 1);
    chk({tag, " first sym latency"}, first_cyc - acc_cyc, 1);
    chk({tag, " bubbles"}, bubbles, nbytes - 1);
    chk({tag, " load visits"}, loads, nbytes);
    chk({tag, " bytes accepted"}, bi, nbytes);
    chk({tag, " stall hold"}, stall_bad, 0);
    chk({tag, " din_ready only in LOAD"}, dr_bad, 0);
    chk({tag, " final st"}, fin_st, 0);
    chk({tag, " idle after done"}, {busy, done, din_ready, sym_valid}, 0);
  endtask

  int cnt, cyc, fb;

  initial begin
    tbl[0] = '{8,  8'hB0, 8'h00, 0, 1'b0, EXP_B0};
    tbl[1] = '{8,  8'hFF, 8'h00, 0, 1'b0, EXP_FF};
    tbl[2] = '{8,  8'hB0, 8'h00, 1, 1'b0, EXP_B0};
    tbl[3] = '{16, 8'hFF, 8'h00, 0, 1'b0, EXP_16};
    tbl[4] = '{16, 8'hFF, 8'h00, 1, 1'b1, EXP_16};
    tbl[5] = '{8,  8'hB0, 8'h00, 0, 1'b1, EXP_B0};

    repeat (2) @(negedge clk);
    chk("reset outputs f8", {dr8, sv8, s8, sl8, b8, d8}, 0);
    chk("reset outputs f16", {dr16, sv16, s16, sl16, b16, d16}, 0);
    chk("reset st", {dut8.st, dut16.st}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].fb, tbl[i].b0, tbl[i].b1,
                tbl[i].rmode, tbl[i].noise, 1'b1, tbl[i].exp);

    // Reset after three symbols of a frame, then a clean frame.
    sel = 1'b0;
    sym_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 50) begin
      din_valid = din_ready;
      din = 8'hB0;
      if (sym_valid && sym_ready) cnt++;
      @(negedge clk);
      cyc++;
    end
    din_valid = 1'b0;
    chk("rst prelude symbols", cnt, 3);
    chk("rst prelude busy", {busy, sym_valid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", {din_ready, sym_valid, sym, sym_last, busy, done}, 0);
    chk("async reset st", dut8.st, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset idle", {din_ready, sym_valid, sym_last, busy, done}, 0);
    run_frame("post_rst", 8, 8'hB0, 8'h00, 0, 1'b0, 1'b1, EXP_B0);

    for (int i = 0; i < 8; i++) begin
      fb = ($urandom_range(0, 1) == 1) ? 16 : 8;
      run_frame($sformatf("rnd%0d", i), fb, 8'($urandom), 8'($urandom), 1,
                1'($urandom_range(0, 1)), 1'b0, 36'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
